// File: rtl/main_memory_capture_ring.sv
// Multi-channel pre-trigger capture ring: circular BRAM write, freeze on trigger,
// then sample-major / channel-minor readout through a two-stage read pipeline.
module main_memory_capture_ring #(
  parameter int ADC_MAX_DATA_SIZE = 16,
  parameter int CH_NUM = 4,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                                i_main_memory_clk,
  input  logic                                i_main_memory_reset,
  input  logic                                i_main_memory_wr_clk_en,
  input  logic [ADC_MAX_DATA_SIZE*CH_NUM-1:0] i_main_memory_wr_data,
  input  logic                                i_main_memory_arm,
  input  logic                                i_main_memory_ext_trig,
  input  logic                                i_main_memory_ext_trig_en,
  input  logic [4:0]                          i_main_memory_capture_req_exp,
  input  logic [DEPTH_LOG2-1:0]               i_main_memory_pretrig,
  input  logic                                i_main_memory_rd_en,
  output logic [ADC_MAX_DATA_SIZE-1:0]        o_main_memory_rd_data,
  output logic                                o_main_memory_rd_valid,
  output logic                                o_main_memory_rd_ready,
  output logic                                o_main_memory_busy,
  output logic [DEPTH_LOG2-1:0]               o_main_memory_trig_addr
);
  localparam int W   = ADC_MAX_DATA_SIZE;
  localparam int D   = DEPTH_LOG2;
  localparam int NW  = D + 1;
  localparam int CHL = $clog2(CH_NUM);
  localparam int CHW = (CHL > 0) ? CHL : 1;
  localparam int WLW = NW + CHW;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;
  state_t state_reg, state_next;

  logic clk, rst;
  assign clk = i_main_memory_clk;
  assign rst = i_main_memory_reset;

  logic [NW-1:0]        n_size_reg;
  logic [D-1:0]         p_eff_reg;
  logic                 trig_en_reg;
  logic [D-1:0]         wr_ptr_reg;
  logic [D-1:0]         pre_cnt_reg;
  logic [NW-1:0]        post_cnt_reg;
  logic                 trig_d_reg;
  logic                 trig_pend_reg;
  logic [D-1:0]         trig_addr_reg;
  logic [D-1:0]         rd_ptr_reg;
  logic [CHW-1:0]       ch_cnt_reg;
  logic [WLW-1:0]       words_left_reg;
  logic [CH_NUM*W-1:0]  ram_q_reg;
  logic [CHW-1:0]       ch_s1_reg;
  logic                 vld_s1_reg;
  logic                 last_s1_reg;
  logic                 last_s2_reg;
  logic [W-1:0]         rd_data_reg;
  logic                 rd_valid_reg;
  logic                 busy, rd_ready;

  logic [CH_NUM*W-1:0]  mem [2**D];

  // Size/pretrigger decode for the arm beat; P is clamped to N-1 so at least one post sample exists
  logic [5:0]    exp_sum, n_log2;
  logic [NW-1:0] n_size_arm;
  logic [D-1:0]  p_arm;
  assign exp_sum    = {1'b0, i_main_memory_capture_req_exp} + 6'd8;
  assign n_log2     = (exp_sum > 6'(D)) ? 6'(D) : exp_sum;
  assign n_size_arm = NW'(1) << n_log2;
  assign p_arm      = ({1'b0, i_main_memory_pretrig} >= n_size_arm) ?
                      D'(n_size_arm - NW'(1)) : i_main_memory_pretrig;

  logic          trig_rise, wr_en, trig_hit, pre_last, post_last, rd_accept;
  logic [NW-1:0] post_target;
  assign trig_rise   = i_main_memory_ext_trig & ~trig_d_reg;
  assign post_target = n_size_reg - {1'b0, p_eff_reg};
  assign wr_en       = i_main_memory_wr_clk_en &&
                       ((state_reg == S_PRE && p_eff_reg != '0) ||
                        state_reg == S_ARMED || state_reg == S_POST);
  assign trig_hit    = (state_reg == S_ARMED) && i_main_memory_wr_clk_en &&
                       (!trig_en_reg || trig_pend_reg || trig_rise);
  assign pre_last    = i_main_memory_wr_clk_en && (pre_cnt_reg + D'(1) == p_eff_reg);
  assign post_last   = i_main_memory_wr_clk_en && (post_cnt_reg + NW'(1) == post_target);
  assign rd_accept   = (state_reg == S_DONE) && i_main_memory_rd_en && (words_left_reg != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (i_main_memory_arm) state_next = S_PRE;
      S_PRE:   if (p_eff_reg == '0 || pre_last) state_next = S_ARMED;
      S_ARMED: if (trig_hit) state_next = (post_target == NW'(1)) ? S_DONE : S_POST;
      S_POST:  if (post_last) state_next = S_DONE;
      S_DONE:  if (rd_valid_reg && last_s2_reg) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    rd_ready = 1'b0;
    case (state_reg)
      S_PRE, S_ARMED, S_POST: busy = 1'b1;
      S_DONE:                 rd_ready = 1'b1;
      default: ;
    endcase
  end

  // Block RAM: contents survive reset, so no reset term here
  always_ff @(posedge clk) begin
    if (wr_en)     mem[wr_ptr_reg] <= i_main_memory_wr_data;
    if (rd_accept) ram_q_reg <= mem[rd_ptr_reg];
  end

  logic [W-1:0] ram_ch [CH_NUM];
  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch_split
    assign ram_ch[gi] = ram_q_reg[gi*W +: W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_size_reg     <= '0;
      p_eff_reg      <= '0;
      trig_en_reg    <= 1'b0;
      wr_ptr_reg     <= '0;
      pre_cnt_reg    <= '0;
      post_cnt_reg   <= '0;
      trig_d_reg     <= 1'b0;
      trig_pend_reg  <= 1'b0;
      trig_addr_reg  <= '0;
      rd_ptr_reg     <= '0;
      ch_cnt_reg     <= '0;
      words_left_reg <= '0;
      ch_s1_reg      <= '0;
      vld_s1_reg     <= 1'b0;
      last_s1_reg    <= 1'b0;
      last_s2_reg    <= 1'b0;
      rd_data_reg    <= '0;
      rd_valid_reg   <= 1'b0;
    end else begin
      trig_d_reg    <= i_main_memory_ext_trig;
      // Edges only count once ARMED; anything seen earlier is dropped
      trig_pend_reg <= (state_reg == S_ARMED) && (trig_pend_reg || trig_rise);
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + D'(1);
      if (state_reg == S_IDLE && i_main_memory_arm) begin
        n_size_reg  <= n_size_arm;
        p_eff_reg   <= p_arm;
        trig_en_reg <= i_main_memory_ext_trig_en;
        pre_cnt_reg <= '0;
      end
      if (state_reg == S_PRE && wr_en) pre_cnt_reg <= pre_cnt_reg + D'(1);
      if (trig_hit) begin
        trig_addr_reg  <= wr_ptr_reg;
        rd_ptr_reg     <= wr_ptr_reg - p_eff_reg;
        post_cnt_reg   <= NW'(1);
        words_left_reg <= WLW'(n_size_reg) << CHL;
        ch_cnt_reg     <= '0;
      end
      if (state_reg == S_POST && wr_en) post_cnt_reg <= post_cnt_reg + NW'(1);
      if (rd_accept) begin
        words_left_reg <= words_left_reg - WLW'(1);
        if (ch_cnt_reg == CHW'(CH_NUM - 1)) begin
          ch_cnt_reg <= '0;
          rd_ptr_reg <= rd_ptr_reg + D'(1);
        end else begin
          ch_cnt_reg <= ch_cnt_reg + CHW'(1);
        end
      end
      vld_s1_reg   <= rd_accept;
      ch_s1_reg    <= ch_cnt_reg;
      last_s1_reg  <= rd_accept && (words_left_reg == WLW'(1));
      rd_valid_reg <= vld_s1_reg;
      last_s2_reg  <= vld_s1_reg && last_s1_reg;
      if (vld_s1_reg) rd_data_reg <= ram_ch[ch_s1_reg];
    end
  end

  assign o_main_memory_rd_data   = rd_data_reg;
  assign o_main_memory_rd_valid  = rd_valid_reg;
  assign o_main_memory_rd_ready  = rd_ready;
  assign o_main_memory_busy      = busy;
  assign o_main_memory_trig_addr = trig_addr_reg;
endmodule
